// File: rtl/lfsr_pkg.sv
// lfsr_pkg: checker states, PRBS7 defaults and the tap function shared by generator and checker.
package lfsr_pkg;

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    localparam int         PRBS7_WIDTH = 7;
    localparam logic [6:0] PRBS7_POLY  = 7'h60;
    localparam int         MAX_WIDTH   = 64;

    // Bit i of poly selects history bit i (history[0] is the newest bit).
    function automatic logic lfsr_next_bit(input logic [MAX_WIDTH-1:0] history,
                                           input logic [MAX_WIDTH-1:0] poly);
        return ^(history & poly);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that holds at all-ones, with synchronous clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_q <= '0;
        else if (clr)
            r_q <= '0;
        else if (inc && r_q != '1)
            r_q <= r_q + 1'b1;
    end

    assign q = r_q;

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronizing PRBS receiver; locks onto the stream, then
// free-runs a local LFSR, counts bit errors and drops lock on dense errors.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int                    LFSR_WIDTH      = PRBS7_WIDTH,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLYNOMIAL = PRBS7_POLY,
    parameter int                    LOCK_CNT        = 16,
    parameter int                    ERR_WIN         = 64,
    parameter int                    ERR_THRESH      = 8,
    parameter int                    CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 din,
    output logic                 locked,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] err_cnt,
    output logic [CNT_WIDTH-1:0] bit_cnt
);

    localparam int FW = $clog2(LFSR_WIDTH + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(ERR_WIN + 1);
    localparam int EW = $clog2(ERR_THRESH + 1);

    state_t                r_state, w_state;
    logic [LFSR_WIDTH-1:0] r_hist, w_hist;
    logic [FW-1:0]         r_fill, w_fill;
    logic [MW-1:0]         r_match, w_match;
    logic [WW-1:0]         r_win_cnt, w_win_cnt;
    logic [EW-1:0]         r_win_err, w_win_err;
    logic                  r_err, w_err;
    logic                  w_p, w_miss, w_wrap, w_bit_inc, w_err_inc;

    assign w_p    = lfsr_next_bit(MAX_WIDTH'(r_hist), MAX_WIDTH'(LFSR_POLYNOMIAL));
    assign w_miss = din != w_p;
    assign w_wrap = r_win_cnt == WW'(ERR_WIN - 1);

    always_comb begin
        w_state   = r_state;
        w_hist    = r_hist;
        w_fill    = r_fill;
        w_match   = r_match;
        w_win_cnt = r_win_cnt;
        w_win_err = r_win_err;
        w_err     = 1'b0;
        w_bit_inc = 1'b0;
        w_err_inc = 1'b0;
        if (clr) begin
            w_state   = HUNT;
            w_hist    = '0;
            w_fill    = '0;
            w_match   = '0;
            w_win_cnt = '0;
            w_win_err = '0;
        end else if (en) begin
            case (r_state)
                HUNT: begin
                    w_hist = {r_hist[LFSR_WIDTH-2:0], din};
                    w_fill = r_fill + 1'b1;
                    if (r_fill == FW'(LFSR_WIDTH - 1)) begin
                        w_state = SYNC;
                        w_match = '0;
                    end
                end
                SYNC: begin
                    w_hist  = {r_hist[LFSR_WIDTH-2:0], din};
                    // an all-zero history predicts 0 forever, so it must never count
                    w_match = (!w_miss && r_hist != '0) ? r_match + 1'b1 : '0;
                    if (!w_miss && r_hist != '0 && r_match == MW'(LOCK_CNT - 1)) begin
                        w_state   = LOCKED;
                        w_win_cnt = '0;
                        w_win_err = '0;
                    end
                end
                LOCKED: begin
                    w_hist    = {r_hist[LFSR_WIDTH-2:0], w_p};
                    w_bit_inc = 1'b1;
                    w_err     = w_miss;
                    w_err_inc = w_miss;
                    w_win_cnt = w_wrap ? '0 : r_win_cnt + 1'b1;
                    w_win_err = w_wrap ? '0 : r_win_err + EW'(w_miss);
                    if (w_miss && r_win_err == EW'(ERR_THRESH - 1)) begin
                        w_state = HUNT;
                        w_fill  = '0;
                    end
                end
                default: w_state = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= HUNT;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= '0;
            r_win_cnt <= '0;
            r_win_err <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_hist    <= w_hist;
            r_fill    <= w_fill;
            r_match   <= w_match;
            r_win_cnt <= w_win_cnt;
            r_win_err <= w_win_err;
            r_err     <= w_err;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .inc     (w_err_inc),
        .q       (err_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_bit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .inc     (w_bit_inc),
        .q       (bit_cnt)
    );

    assign locked = r_state == LOCKED;
    assign err    = r_err;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed bench for lfsr_checker against a reference PRBS7 stream;
// a second instance with 4-bit counters covers saturation.
module tb_lfsr_checker;

    logic        clk = 1'b0, reset_n = 1'b0, clr = 1'b0, en = 1'b0, din = 1'b0;
    logic        locked, err, locked_s, err_s;
    logic [15:0] err_cnt, bit_cnt;
    logic [3:0]  err_cnt_s, bit_cnt_s;
    logic [6:0]  ref_r = 7'h5B;
    int          checks = 0, errors = 0, err_pulses = 0, gap_err = 0;
    bit          gaps = 1'b0, any_lock, any_err;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .din(din),
        .locked(locked), .err(err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    lfsr_checker #(.CNT_WIDTH(4), .ERR_WIN(64), .ERR_THRESH(64)) dut_s (
        .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .din(din),
        .locked(locked_s), .err(err_s), .err_cnt(err_cnt_s), .bit_cnt(bit_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One en sample of the reference stream s[n]=s[n-6]^s[n-7], optionally inverted.
    task automatic send(input bit flip);
        bit b;
        int g = 0;
        if (gaps)
            while ($urandom_range(0, 99) >= 30 && g < 100) begin
                en = 1'b0;
                tick();
                if (err) gap_err++;
                g++;
            end
        b = ref_r[5] ^ ref_r[6];
        ref_r = {ref_r[5:0], b};
        en = 1'b1;
        din = b ^ flip;
        tick();
        en = 1'b0;
        if (err) err_pulses++;
    endtask

    task automatic send_n(input int n);
        repeat (n) send(1'b0);
    endtask

    initial begin
        #3;
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_bit_cnt", 32'(bit_cnt), 0);
        reset_n = 1'b1;
        tick();

        send_n(22);
        chk("lock_22", 32'(locked), 0);
        send_n(1);
        chk("lock_23", 32'(locked), 1);
        send_n(14);
        chk("sat_bit_14", 32'(bit_cnt_s), 14);
        send_n(986);
        chk("clean_err_cnt", 32'(err_cnt), 0);
        chk("clean_bit_cnt", 32'(bit_cnt), 1000);
        chk("clean_pulses", 32'(err_pulses), 0);
        chk("sat_bit_hold", 32'(bit_cnt_s), 15);

        send_n(199);
        send(1'b1);
        chk("single_err_pulse", 32'(err), 1);
        send_n(300);
        chk("single_err_cnt", 32'(err_cnt), 1);
        chk("single_pulses", 32'(err_pulses), 1);
        chk("single_locked", 32'(locked), 1);
        chk("single_bit_cnt", 32'(bit_cnt), 1500);

        for (int i = 0; i < 640; i++) send(i % 10 == 0);
        chk("seven_locked", 32'(locked), 1);
        chk("seven_err_cnt", 32'(err_cnt), 65);
        chk("sat_err_cnt", 32'(err_cnt_s), 15);
        chk("sat_bit_cnt", 32'(bit_cnt_s), 15);
        chk("sat_locked", 32'(locked_s), 1);

        send_n(36);
        repeat (7) send(1'b1);
        chk("loss_7_locked", 32'(locked), 1);
        chk("loss_7_err_cnt", 32'(err_cnt), 72);
        send(1'b1);
        chk("loss_8_err", 32'(err), 1);
        chk("loss_8_locked", 32'(locked), 0);
        chk("loss_8_err_cnt", 32'(err_cnt), 73);
        chk("loss_8_bit_cnt", 32'(bit_cnt), 2184);
        send_n(22);
        chk("relock_22", 32'(locked), 0);
        send_n(1);
        chk("relock_23", 32'(locked), 1);
        chk("relock_bit_cnt", 32'(bit_cnt), 2184);

        clr = 1'b1;
        en = 1'b1;
        din = ~(ref_r[5] ^ ref_r[6]);
        tick();
        clr = 1'b0;
        en = 1'b0;
        chk("clr_locked", 32'(locked), 0);
        chk("clr_err", 32'(err), 0);
        chk("clr_err_cnt", 32'(err_cnt), 0);
        chk("clr_bit_cnt", 32'(bit_cnt), 0);
        chk("clr_sat_err_cnt", 32'(err_cnt_s), 0);
        send_n(22);
        chk("clr_relock_22", 32'(locked), 0);
        send_n(1);
        chk("clr_relock_23", 32'(locked), 1);

        send_n(9);
        send(1'b1);
        chk("pre_rst_err", 32'(err), 1);
        chk("pre_rst_bit_cnt", 32'(bit_cnt), 10);
        #2 reset_n = 1'b0;
        #1;
        chk("async_locked", 32'(locked), 0);
        chk("async_err", 32'(err), 0);
        chk("async_err_cnt", 32'(err_cnt), 0);
        chk("async_bit_cnt", 32'(bit_cnt), 0);
        #2 reset_n = 1'b1;

        any_lock = 1'b0;
        any_err = 1'b0;
        en = 1'b1;
        din = 1'b0;
        repeat (500) begin
            tick();
            any_lock |= locked;
            any_err |= err;
        end
        din = 1'b1;
        repeat (500) begin
            tick();
            any_lock |= locked;
            any_err |= err;
        end
        en = 1'b0;
        chk("stuck_never_locked", 32'(any_lock), 0);
        chk("stuck_no_err", 32'(any_err), 0);
        chk("stuck_err_cnt", 32'(err_cnt), 0);

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        ref_r = 7'h5B;
        gaps = 1'b1;
        err_pulses = 0;
        send_n(22);
        chk("gap_lock_22", 32'(locked), 0);
        send_n(1);
        chk("gap_lock_23", 32'(locked), 1);
        send_n(1000);
        chk("gap_err_cnt", 32'(err_cnt), 0);
        chk("gap_bit_cnt", 32'(bit_cnt), 1000);
        chk("gap_pulses", 32'(err_pulses), 0);
        chk("gap_idle_err", 32'(gap_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
